// File: rtl/rec_df_pingpong_buf.sv
// Ping-pong SRAM between reconstruction (writer) and deblocking filter (reader).
// Ports: clk/reset_n; wr_* writer side; rd_* reader side; bank, error, ram_active status.
module rec_df_pingpong_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 96
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_done,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_done,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic              err_wr,
  output logic              err_rd,
  output logic              ram_active
);

  localparam int MEM_AW = $clog2(2 * DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [MEM_AW-1:0] BANK_OFS = MEM_AW'(DEPTH);

  logic [DATA_W-1:0] mem [2*DEPTH];

  // one bit per bank: 1 = FULL, 0 = EMPTY
  logic [1:0] full_q;
  logic [1:0] full_d;

  logic wr_in_rng;
  logic rd_in_rng;
  logic wr_acc;
  logic rd_acc;
  logic wr_close;
  logic rd_release;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;

  assign wr_ready = ~full_q[wr_bank];
  assign rd_valid = full_q[rd_bank];

  assign wr_in_rng = {1'b0, wr_addr} < LIMIT;
  assign rd_in_rng = {1'b0, rd_addr} < LIMIT;

  // nothing is accepted while reset is held, so the
  // memory and the gate enable stay quiet during reset
  assign wr_acc = reset_n & wr_en & wr_ready & wr_in_rng;
  assign rd_acc = reset_n & rd_en & rd_valid & rd_in_rng;

  assign wr_close   = wr_done & wr_ready;
  assign rd_release = rd_done & rd_valid;

  assign ram_active = wr_acc | rd_acc;

  assign wr_idx = wr_bank
                ? BANK_OFS + MEM_AW'(wr_addr)
                : MEM_AW'(wr_addr);
  assign rd_idx = rd_bank
                ? BANK_OFS + MEM_AW'(rd_addr)
                : MEM_AW'(rd_addr);

  // wr_close needs EMPTY and rd_release needs FULL,
  // so they never target the same bank
  always_comb begin
    full_d = full_q;
    if (wr_close) full_d[wr_bank] = 1'b1;
    if (rd_release) full_d[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q      <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
      err_wr      <= 1'b0;
      err_rd      <= 1'b0;
    end else begin
      full_q      <= full_d;
      rd_data_vld <= rd_acc;
      // data is captured before a same-cycle release
      if (rd_acc) rd_data <= mem[rd_idx];
      if (wr_close) wr_bank <= ~wr_bank;
      if (rd_release) rd_bank <= ~rd_bank;
      if ((wr_en & ~wr_acc) | (wr_done & ~wr_ready))
        err_wr <= 1'b1;
      if ((rd_en & ~rd_acc) | (rd_done & ~rd_valid))
        err_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rec_df_pingpong_buf.sv
// Self-checking bench for rec_df_pingpong_buf.
// Bank-level model plus directed literal checks.
module tb_rec_df_pingpong_buf;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int DEPTH = 96;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic wr_done = 1'b0;
  logic rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic rd_done = 1'b0;
  logic wr_ready, rd_valid, rd_data_vld;
  logic [DW-1:0] rd_data;
  logic wr_bank, rd_bank, err_wr, err_rd, ram_active;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rec_df_pingpong_buf #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_done(wr_done),
    .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_data_vld(rd_data_vld),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .err_wr(err_wr), .err_rd(err_rd),
    .ram_active(ram_active)
  );

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mmem [2][DEPTH];
  bit mfull [2];
  bit mwb, mrb, merr_wr, merr_rd, mvld, mlive;
  logic [DW-1:0] mrd;

  function automatic bit m_wacc();
    return reset_n && wr_en && !mfull[mwb]
        && int'(wr_addr) < DEPTH;
  endfunction

  function automatic bit m_racc();
    return reset_n && rd_en && mfull[mrb]
        && int'(rd_addr) < DEPTH;
  endfunction

  always @(posedge clk) begin : model
    bit wa, ra, wc, rr;
    if (!reset_n) begin
      mfull[0] = 0; mfull[1] = 0;
      mwb = 0; mrb = 0;
      merr_wr = 0; merr_rd = 0;
      mrd = '0; mvld = 0;
      mlive = 1;
    end else begin
      wa = m_wacc();
      ra = m_racc();
      wc = wr_done && !mfull[mwb];
      rr = rd_done && mfull[mrb];
      if ((wr_en && !wa) || (wr_done && !wc)) merr_wr = 1;
      if ((rd_en && !ra) || (rd_done && !rr)) merr_rd = 1;
      mvld = ra;
      if (ra) mrd = mmem[mrb][int'(rd_addr)];
      if (wa) mmem[mwb][int'(wr_addr)] = wr_data;
      if (wc) begin mfull[mwb] = 1; mwb = !mwb; end
      if (rr) begin mfull[mrb] = 0; mrb = !mrb; end
    end
  end

  always @(negedge clk) begin
    if (mlive) begin
      chk("wr_ready", wr_ready, !mfull[mwb]);
      chk("rd_valid", rd_valid, mfull[mrb]);
      chk("rd_data", rd_data, mrd);
      chk("rd_data_vld", rd_data_vld, mvld);
      chk("wr_bank", wr_bank, mwb);
      chk("rd_bank", rd_bank, mrb);
      chk("err_wr", err_wr, merr_wr);
      chk("err_rd", err_rd, merr_rd);
      chk("ram_active", ram_active, m_wacc() || m_racc());
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit we, input int wa,
                      input logic [DW-1:0] wd, input bit wdn,
                      input bit re, input int ra, input bit rdn);
    wr_en = we; wr_addr = wa[AW-1:0]; wr_data = wd;
    wr_done = wdn;
    rd_en = re; rd_addr = ra[AW-1:0]; rd_done = rdn;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    reset_n = 0;
    idle(); idle();
    reset_n = 1;
    chk("rst wr_ready", wr_ready, 1);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst err_wr", err_wr, 0);

    for (int a = 0; a < DEPTH; a++)
      step(1, a, 32'hA500_0000 + a, 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 0);
    chk("fill wr_bank", wr_bank, 1);
    chk("fill rd_valid", rd_valid, 1);

    step(0, 0, '0, 0, 1, 5, 0);
    chk("rd5 vld", rd_data_vld, 1);
    chk("rd5 data", rd_data, 32'hA500_0005);
    idle();
    chk("hold vld", rd_data_vld, 0);
    chk("hold data", rd_data, 32'hA500_0005);

    for (int a = 0; a < DEPTH - 1; a++)
      step(1, a, 32'h5A00_0000 + a, 0, 1, a, 0);
    chk("pp rd94", rd_data, 32'hA500_005E);
    step(1, 95, 32'h5A00_005F, 1, 0, 0, 0);
    chk("both full wr_ready", wr_ready, 0);
    chk("both full wr_bank", wr_bank, 0);

    step(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
    chk("full drop err_wr", err_wr, 1);
    step(0, 0, '0, 0, 1, 3, 1);
    chk("rd+done data", rd_data, 32'hA500_0003);
    chk("rd+done vld", rd_data_vld, 1);
    chk("rd+done rd_bank", rd_bank, 1);
    chk("rd+done wr_ready", wr_ready, 1);
    step(0, 0, '0, 0, 1, 95, 0);
    chk("b1 rd95", rd_data, 32'h5A00_005F);
    step(0, 0, '0, 0, 1, 7, 0);
    chk("b1 rd7", rd_data, 32'h5A00_0007);

    for (int a = 0; a < 4; a++)
      step(1, a, 32'h1111_0000 + a, 0, 0, 0, 0);
    step(0, 0, '0, 1, 0, 0, 1);
    chk("sim wr_bank", wr_bank, 1);
    chk("sim rd_bank", rd_bank, 0);
    chk("sim rd_valid", rd_valid, 1);
    chk("sim wr_ready", wr_ready, 1);
    step(0, 0, '0, 0, 1, 2, 0);
    chk("sim rd2", rd_data, 32'h1111_0002);

    step(0, 0, '0, 1, 0, 0, 0);
    chk("mid wr_ready", wr_ready, 0);
    reset_n = 0;
    step(0, 0, '0, 0, 1, 2, 0);
    chk("mid vld", rd_data_vld, 0);
    chk("mid rd_data", rd_data, 0);
    chk("mid wr_ready2", wr_ready, 1);
    chk("mid rd_valid", rd_valid, 0);
    chk("mid wr_bank", wr_bank, 0);
    chk("mid err_wr", err_wr, 0);
    reset_n = 1;

    step(1, 96, 32'h0BAD_0060, 0, 0, 0, 0);
    chk("wr96 err_wr", err_wr, 1);
    chk("wr96 err_rd", err_rd, 0);
    step(1, 127, 32'h0BAD_007F, 0, 0, 0, 0);
    step(0, 0, '0, 0, 1, 0, 0);
    chk("rd empty err_rd", err_rd, 1);
    chk("rd empty vld", rd_data_vld, 0);

    reset_n = 0;
    idle();
    reset_n = 1;
    step(1, 0, 32'h0000_0077, 1, 0, 0, 0);
    chk("wr+done err_wr", err_wr, 0);
    step(0, 0, '0, 0, 1, 96, 0);
    chk("rd96 vld", rd_data_vld, 0);
    chk("rd96 err_rd", err_rd, 1);
    step(0, 0, '0, 0, 1, 0, 0);
    chk("closed bank rd0", rd_data, 32'h0000_0077);
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rec_df_pingpong_buf.md
Name: rec_df_pingpong_buf

Overview:
- Parametrised double-buffered SRAM between reconstruction (writer) and deblocking filter (reader); successor to the single-bank 96x32 rec/DF RAM.
- Two banks of DEPTH x DATA_W. Reconstruction fills one bank while the deblocking filter drains the other; banks swap through a full/empty handshake.
- Adds per-bank state, an address range check, sticky error flags, and a RAM activity output for clock gating.

Parameters:
- DATA_W, 32: data word width.
- ADDR_W, 7: word address width within a bank.
- DEPTH, 96: words per bank; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write strobe from reconstruction.
- wr_addr  in  ADDR_W  write word address in the current write bank.
- wr_data  in  DATA_W  write data.
- wr_done  in  1  pulse: current write bank is complete; mark it FULL.
- wr_ready  out  1  current write bank is EMPTY and writable.
- rd_en  in  1  read strobe from deblocking filter.
- rd_addr  in  ADDR_W  read word address in the current read bank.
- rd_done  in  1  pulse: current read bank is consumed; mark it EMPTY.
- rd_valid  out  1  current read bank is FULL and readable.
- rd_data  out  DATA_W  registered read data.
- rd_data_vld  out  1  rd_data was updated this cycle.
- wr_bank, rd_bank  out  1 each  current write and read bank index.
- err_wr, err_rd  out  1 each  sticky protocol error flags.
- ram_active  out  1  a write or read is accepted this cycle; drives the clock-gate enable.

Behaviour:
- Storage: bank b, address a maps to mem[b*DEPTH + a]. Storage is not reset.
- Reset values (synchronous):
  - Both banks EMPTY; wr_bank = 0; rd_bank = 0.
  - wr_ready = 1; rd_valid = 0; rd_data = 0; rd_data_vld = 0; err_wr = 0; err_rd = 0; ram_active = 0.
- Write:
  - Accepted when wr_en & wr_ready & (wr_addr < DEPTH). Memory is updated at that clock edge.
  - wr_en with wr_ready = 0, or with wr_addr >= DEPTH: the write is dropped and err_wr is set.
- Write done:
  - wr_done & wr_ready: the bank becomes FULL and wr_bank toggles on the next cycle.
  - wr_done & !wr_ready: ignored; err_wr is set.
  - A write accepted in the same cycle as wr_done lands in the bank being closed.
- Read:
  - Accepted when rd_en & rd_valid & (rd_addr < DEPTH).
  - rd_data = mem[rd_bank, rd_addr] one cycle later, with rd_data_vld = 1 for exactly that cycle.
  - Otherwise rd_data holds its value and rd_data_vld = 0.
  - An invalid read (rd_valid = 0 or rd_addr >= DEPTH) sets err_rd and produces no rd_data_vld.
- Read done:
  - rd_done & rd_valid: the bank becomes EMPTY and rd_bank toggles.
  - rd_done & !rd_valid: ignored; err_rd is set.
  - A read accepted in the same cycle as rd_done still returns its data next cycle, because the data is captured before the bank is released.
- Bank state:
  - wr_ready = (state[wr_bank] == EMPTY); rd_valid = (state[rd_bank] == FULL). Both are combinational from registered state.
  - wr_done and rd_done always act on different banks, because one requires EMPTY and the other FULL. They may occur in the same cycle; both take effect.
- Both banks FULL: wr_ready = 0; the writer stalls until rd_done.
- Both banks EMPTY: rd_valid = 0; the reader stalls until wr_done.
- Handshake latency: a bank marked FULL by wr_done shows rd_valid = 1 on the next cycle (when rd_bank points to it). Same for EMPTY → wr_ready.
- Error flags are sticky and cleared only by reset.
- ram_active = accepted write | accepted read. It is combinational, for the external clock gate only.
- Reset asserted mid-operation:
  - Pending read data is discarded (rd_data_vld = 0) and all bank state returns to EMPTY.
  - Memory contents are undefined-but-unchanged.

Test Plan:
- Reset, then write addresses 0..95 with data 0xA5000000+addr, pulse wr_done → next cycle wr_bank = 1, rd_valid = 1; read address 5 → rd_data = 0xA5000005 one cycle later with rd_data_vld = 1.
- Ping-pong: fill bank 1 with 0x5A000000+addr while reading bank 0; rd_done then read address 95 → 0x5A00005F; no cross-bank corruption.
- Both banks full: wr_done twice without rd_done → wr_ready = 0; a write then sets err_wr = 1 and bank contents are unchanged; rd_done → wr_ready = 1 next cycle.
- Boundary: write to addr 96 or 127 → dropped, err_wr = 1; read from addr 96 → no rd_data_vld, err_rd = 1. Read while both banks empty → err_rd = 1.
- Simultaneous events: wr_done and rd_done in the same cycle → both banks swap state correctly. A read with rd_done in the same cycle returns correct data. A write with wr_done in the same cycle lands in the closed bank.
- Mid-operation reset after one wr_done → wr_ready = 1, rd_valid = 0, wr_bank = 0, rd_bank = 0, err flags = 0, rd_data = 0.
